// File: rtl/apb_bus_pkg.sv
// Shared types and constants for the parametrised APB interconnect.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package apb_bus_pkg;

  // Bus phase seen by the bridge; SETUP is recognised combinationally from the master.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_TOERR  = 2'd3
  } apb_state_t;

  // Read data returned on any bridge-generated error response.
  localparam int ERR_RDATA = 0;

  // Width of the saturating bridge-error counter.
  localparam int ERR_CNT_W = 8;

  // Slave index width; never narrower than one bit so a single-slave build still has a vector.
  function automatic int slv_idx_w(input int num_slaves);
    return (num_slaves > 1) ? $clog2(num_slaves) : 1;
  endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Regular-map address decoder: hit flag and slave index for an APB address.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the address input.
module apb_addr_decoder #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    NUM_SLAVES = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    REGION_AW  = 12,
  parameter int                    IDX_W      = 2
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  hit,
  output logic [IDX_W-1:0]      idx
);

  // One extra bit so NUM_SLAVES regions spanning the whole address space cannot wrap to zero.
  localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH+1)'(NUM_SLAVES) << REGION_AW;

  logic [ADDR_WIDTH-1:0] offset;

  // Addresses below the base wrap to large offsets and therefore miss.
  always_comb begin
    offset = addr - BASE_ADDR;
    hit    = ({1'b0, offset} < SPAN);
    idx    = IDX_W'(offset >> REGION_AW);
  end

endmodule

// File: rtl/apb_bus_nslv.sv
// One-master to NUM_SLAVES APB interconnect with decode-miss errors and sticky error capture.
// Latency: hits add no wait states; misses finish in the first access cycle; timeouts in access cycle TIMEOUT_CYCLES+1.
// Backpressure: slave PREADY passes straight to the master; APB_BUS_TIMEOUT_EN builds a watchdog that ends hung transfers.
module apb_bus_nslv
  import apb_bus_pkg::*;
#(
  parameter int                    NUM_SLAVES     = 4,
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                    REGION_AW      = 12,
  parameter int                    TIMEOUT_CYCLES = 64
) (
  input  logic                             PCLK,
  input  logic                             PRESETn,
  input  logic [ADDR_WIDTH-1:0]            PADDR_M,
  input  logic                             PSEL_M,
  input  logic                             PENABLE_M,
  input  logic                             PWRITE_M,
  input  logic [DATA_WIDTH-1:0]            PWDATA_M,
  output logic [DATA_WIDTH-1:0]            PRDATA_M,
  output logic                             PREADY_M,
  output logic                             PSLVERR_M,
  output logic [NUM_SLAVES-1:0]            PSEL_S,
  output logic                             PENABLE_S,
  output logic                             PWRITE_S,
  output logic [ADDR_WIDTH-1:0]            PADDR_S,
  output logic [DATA_WIDTH-1:0]            PWDATA_S,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA_S,
  input  logic [NUM_SLAVES-1:0]            PREADY_S,
  input  logic [NUM_SLAVES-1:0]            PSLVERR_S,
  output logic                             err_pulse,
  output logic [ERR_CNT_W-1:0]             err_count,
  output logic [ADDR_WIDTH-1:0]            err_addr,
  output logic                             err_is_timeout
);

  localparam int                    IDX_W      = slv_idx_w(NUM_SLAVES);
  localparam logic [ADDR_WIDTH-1:0] LOCAL_MASK = (ADDR_WIDTH'(1) << REGION_AW) - ADDR_WIDTH'(1);

  apb_state_t            state_q, state_d, phase;
  logic                  dec_hit;
  logic [IDX_W-1:0]      dec_idx;
  logic                  hit_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  xfer_on;
  logic                  sel_rdy;
  logic                  sel_err;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic                  wd_expire;
  logic                  err_ev;

  apb_addr_decoder #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_SLAVES (NUM_SLAVES),
    .BASE_ADDR  (BASE_ADDR),
    .REGION_AW  (REGION_AW),
    .IDX_W      (IDX_W)
  ) u_dec (
    .addr (PADDR_M),
    .hit  (dec_hit),
    .idx  (dec_idx)
  );

  // Shared slave-side fields are plain pass-through; only selects and enable are gated.
  assign PADDR_S  = (PADDR_M - BASE_ADDR) & LOCAL_MASK;
  assign PWDATA_S = PWDATA_M;
  assign PWRITE_S = PWRITE_M;

  assign xfer_on   = PSEL_M & PENABLE_M;
  assign sel_rdy   = PREADY_S[idx_q];
  assign sel_err   = PSLVERR_S[idx_q];
  assign sel_rdata = PRDATA_S[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];

  // A master setup phase seen while idle is the SETUP state; no registered cycle is spent on it.
  always_comb begin
    phase = state_q;
    if (state_q == ST_IDLE && PSEL_M && !PENABLE_M) begin
      phase = ST_SETUP;
    end
  end

  // Next state and all master/slave handshake outputs.
  always_comb begin
    state_d   = state_q;
    PSEL_S    = '0;
    PENABLE_S = 1'b0;
    PREADY_M  = 1'b0;
    PSLVERR_M = 1'b0;
    PRDATA_M  = DATA_WIDTH'(ERR_RDATA);
    err_ev    = 1'b0;
    case (phase)
      ST_SETUP: begin
        if (dec_hit) begin
          PSEL_S = NUM_SLAVES'(1) << dec_idx;
        end
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (!xfer_on) begin
          // Master gave up mid-transfer: drop everything silently.
          state_d = ST_IDLE;
        end else if (hit_q) begin
          PSEL_S    = NUM_SLAVES'(1) << idx_q;
          PENABLE_S = 1'b1;
          PREADY_M  = sel_rdy;
          PSLVERR_M = sel_err;
          PRDATA_M  = sel_rdata;
          if (sel_rdy) begin
            state_d = ST_IDLE;
          end else if (wd_expire) begin
            state_d = ST_TOERR;
          end
        end else begin
          PREADY_M  = 1'b1;
          PSLVERR_M = 1'b1;
          err_ev    = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_TOERR: begin
        // Slave is deselected here, so a late PREADY from it has no effect.
        if (xfer_on) begin
          PREADY_M  = 1'b1;
          PSLVERR_M = 1'b1;
          err_ev    = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; decode result is captured at the end of SETUP and held for the transfer.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q <= ST_IDLE;
      hit_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      if (phase == ST_SETUP) begin
        hit_q <= dec_hit;
        idx_q <= dec_idx;
      end
    end
  end

  // Sticky error capture, updated on the edge that ends a bridge-error completion cycle.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      err_pulse <= 1'b0;
      err_count <= '0;
      err_addr  <= '0;
    end else begin
      err_pulse <= err_ev;
      if (err_ev) begin
        err_addr <= PADDR_M;
        if (err_count != {ERR_CNT_W{1'b1}}) begin
          err_count <= err_count + ERR_CNT_W'(1);
        end
      end
    end
  end

`ifdef APB_BUS_TIMEOUT_EN
  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wd_cnt_q;

  // Fires when this unanswered access cycle brings the count to TIMEOUT_CYCLES.
  assign wd_expire = (wd_cnt_q == CNT_LAST);

  // Watchdog: cleared in SETUP, counts access cycles the selected slave leaves unanswered.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      wd_cnt_q <= '0;
    end else if (phase == ST_SETUP) begin
      wd_cnt_q <= '0;
    end else if (phase == ST_ACCESS && xfer_on && hit_q && !sel_rdy) begin
      wd_cnt_q <= wd_cnt_q + CNT_W'(1);
    end
  end

  // Records which kind of bridge error happened last.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      err_is_timeout <= 1'b0;
    end else if (err_ev) begin
      err_is_timeout <= (phase == ST_TOERR);
    end
  end
`else
  // No watchdog: a slave that never answers holds the bus.
  assign wd_expire      = 1'b0;
  assign err_is_timeout = 1'b0;

  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_apb_bus_nslv.sv
// Directed self-checking bench for apb_bus_nslv (4 slaves, base 0x4000_0000, 4 KiB regions).
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: slave PREADY vectors are driven per access cycle to model waiting slaves.
module tb_apb_bus_nslv;

  localparam int          NS   = 4;
  localparam int          AW   = 32;
  localparam int          DW   = 32;
  localparam int          RAW  = 12;
  localparam int          TO   = 4;
  localparam logic [31:0] BASE = 32'h4000_0000;

  logic           PCLK = 1'b0;
  logic           PRESETn;
  logic [AW-1:0]  PADDR_M;
  logic           PSEL_M, PENABLE_M, PWRITE_M;
  logic [DW-1:0]  PWDATA_M;
  logic [DW-1:0]  PRDATA_M;
  logic           PREADY_M, PSLVERR_M;
  logic [NS-1:0]  PSEL_S;
  logic           PENABLE_S, PWRITE_S;
  logic [AW-1:0]  PADDR_S;
  logic [DW-1:0]  PWDATA_S;
  logic [NS*DW-1:0] PRDATA_S;
  logic [NS-1:0]  PREADY_S, PSLVERR_S;
  logic           err_pulse;
  logic [7:0]     err_count;
  logic [AW-1:0]  err_addr;
  logic           err_is_timeout;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_cnt;

  apb_bus_nslv #(
    .NUM_SLAVES     (NS),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .BASE_ADDR      (BASE),
    .REGION_AW      (RAW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .PCLK           (PCLK),
    .PRESETn        (PRESETn),
    .PADDR_M        (PADDR_M),
    .PSEL_M         (PSEL_M),
    .PENABLE_M      (PENABLE_M),
    .PWRITE_M       (PWRITE_M),
    .PWDATA_M       (PWDATA_M),
    .PRDATA_M       (PRDATA_M),
    .PREADY_M       (PREADY_M),
    .PSLVERR_M      (PSLVERR_M),
    .PSEL_S         (PSEL_S),
    .PENABLE_S      (PENABLE_S),
    .PWRITE_S       (PWRITE_S),
    .PADDR_S        (PADDR_S),
    .PWDATA_S       (PWDATA_S),
    .PRDATA_S       (PRDATA_S),
    .PREADY_S       (PREADY_S),
    .PSLVERR_S      (PSLVERR_S),
    .err_pulse      (err_pulse),
    .err_count      (err_count),
    .err_addr       (err_addr),
    .err_is_timeout (err_is_timeout)
  );

  always #5 PCLK = ~PCLK;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Master setup phase for one cycle.
  task automatic cyc_setup(input logic [31:0] a, input logic w, input logic [31:0] d);
    @(posedge PCLK); #1;
    PSEL_M = 1'b1; PENABLE_M = 1'b0; PADDR_M = a; PWRITE_M = w; PWDATA_M = d;
    @(negedge PCLK);
  endtask

  // One access cycle with the given slave ready vector.
  task automatic cyc_access(input logic [NS-1:0] rdy);
    @(posedge PCLK); #1;
    PENABLE_M = 1'b1; PREADY_S = rdy;
    @(negedge PCLK);
  endtask

  // Master idle for one cycle.
  task automatic cyc_idle();
    @(posedge PCLK); #1;
    PSEL_M = 1'b0; PENABLE_M = 1'b0; PREADY_S = '1;
    @(negedge PCLK);
  endtask

  initial begin
    PRESETn = 1'b0; PSEL_M = 1'b0; PENABLE_M = 1'b0; PWRITE_M = 1'b0;
    PADDR_M = '0; PWDATA_M = '0; PREADY_S = '1; PSLVERR_S = '0;
    PRDATA_S = {32'h3333_4444, 32'h2222_3333, 32'h1111_2222, 32'hA5A5_A5A5};
    repeat (3) @(posedge PCLK);
    #1 PRESETn = 1'b1;
    @(negedge PCLK);

    // Reset state
    check_eq("rst_psel",    PSEL_S,         32'h0);
    check_eq("rst_pready",  PREADY_M,       32'h0);
    check_eq("rst_pslverr", PSLVERR_M,      32'h0);
    check_eq("rst_prdata",  PRDATA_M,       32'h0);
    check_eq("rst_pulse",   err_pulse,      32'h0);
    check_eq("rst_cnt",     err_count,      32'h0);
    check_eq("rst_eaddr",   err_addr,       32'h0);
    check_eq("rst_eto",     err_is_timeout, 32'h0);

    // Write hit on slave 2, offset 0x10
    cyc_setup(BASE + 32'h2010, 1'b1, 32'hDEAD_BEEF);
    check_eq("wr_setup_psel",   PSEL_S,    32'h4);
    check_eq("wr_setup_paddr",  PADDR_S,   32'h010);
    check_eq("wr_setup_pen",    PENABLE_S, 32'h0);
    check_eq("wr_setup_pwrite", PWRITE_S,  32'h1);
    cyc_access(4'hF);
    check_eq("wr_acc_psel",   PSEL_S,    32'h4);
    check_eq("wr_acc_pen",    PENABLE_S, 32'h1);
    check_eq("wr_acc_pready", PREADY_M,  32'h1);
    check_eq("wr_acc_perr",   PSLVERR_M, 32'h0);
    check_eq("wr_acc_pwdata", PWDATA_S,  32'hDEAD_BEEF);
    cyc_idle();
    check_eq("wr_done_psel",  PSEL_S,    32'h0);
    check_eq("wr_done_pulse", err_pulse, 32'h0);

    // Read hit on slave 1, then a slave-reported error from slave 3 (not a bridge error)
    cyc_setup(BASE + 32'h1004, 1'b0, 32'h0);
    check_eq("rd1_psel", PSEL_S, 32'h2);
    cyc_access(4'hF);
    check_eq("rd1_prdata", PRDATA_M, 32'h1111_2222);
    check_eq("rd1_pready", PREADY_M, 32'h1);
    PSLVERR_S = 4'b1000;
    cyc_setup(BASE + 32'h3000, 1'b0, 32'h0);
    cyc_access(4'hF);
    check_eq("s3err_perr",   PSLVERR_M, 32'h1);
    check_eq("s3err_prdata", PRDATA_M,  32'h3333_4444);
    cyc_idle();
    check_eq("s3err_pulse", err_pulse, 32'h0);
    check_eq("s3err_cnt",   err_count, 32'h0);
    PSLVERR_S = '0;

    // Decode miss just past the last region
    cyc_setup(BASE + 32'h4000, 1'b0, 32'h0);
    check_eq("miss_setup_psel", PSEL_S, 32'h0);
    cyc_access(4'hF);
    check_eq("miss_psel",   PSEL_S,    32'h0);
    check_eq("miss_pen",    PENABLE_S, 32'h0);
    check_eq("miss_pready", PREADY_M,  32'h1);
    check_eq("miss_perr",   PSLVERR_M, 32'h1);
    check_eq("miss_prdata", PRDATA_M,  32'h0);
    check_eq("miss_pulse_early", err_pulse, 32'h0);
    cyc_idle();
    check_eq("miss_pulse", err_pulse,      32'h1);
    check_eq("miss_cnt",   err_count,      32'h1);
    check_eq("miss_eaddr", err_addr,       BASE + 32'h4000);
    check_eq("miss_eto",   err_is_timeout, 32'h0);
    cyc_idle();
    check_eq("miss_pulse_off", err_pulse, 32'h0);

    // Decode miss below the base
    cyc_setup(32'h3FFF_FFFC, 1'b0, 32'h0);
    cyc_access(4'hF);
    check_eq("below_perr", PSLVERR_M, 32'h1);
    cyc_idle();
    check_eq("below_cnt",   err_count, 32'h2);
    check_eq("below_eaddr", err_addr,  32'h3FFF_FFFC);
    exp_cnt = 2;

`ifdef APB_BUS_TIMEOUT_EN
    // Slave 1 never answers: bridge ends the transfer in access cycle TO+1
    cyc_setup(BASE + 32'h1008, 1'b0, 32'h0);
    for (int k = 1; k <= TO; k++) begin
      cyc_access(4'b1101);
      check_eq($sformatf("to_wait%0d_pready", k), PREADY_M, 32'h0);
    end
    cyc_access(4'b1111);
    check_eq("to_pready", PREADY_M,  32'h1);
    check_eq("to_perr",   PSLVERR_M, 32'h1);
    check_eq("to_prdata", PRDATA_M,  32'h0);
    check_eq("to_psel",   PSEL_S,    32'h0);
    check_eq("to_pen",    PENABLE_S, 32'h0);
    cyc_idle();
    exp_cnt = exp_cnt + 1;
    check_eq("to_pulse", err_pulse,      32'h1);
    check_eq("to_eto",   err_is_timeout, 32'h1);
    check_eq("to_eaddr", err_addr,       BASE + 32'h1008);
    check_eq("to_cnt",   err_count,      exp_cnt);
`else
    // No watchdog: a silent slave stalls the bus, then completes normally
    cyc_setup(BASE + 32'h1008, 1'b0, 32'h0);
    for (int k = 1; k <= 10; k++) begin
      cyc_access(4'b1101);
    end
    check_eq("hang_pready", PREADY_M, 32'h0);
    check_eq("hang_psel",   PSEL_S,   32'h2);
    cyc_access(4'b1111);
    check_eq("hang_done_pready", PREADY_M,  32'h1);
    check_eq("hang_done_perr",   PSLVERR_M, 32'h0);
    cyc_idle();
    check_eq("hang_eto", err_is_timeout, 32'h0);
    check_eq("hang_cnt", err_count,      exp_cnt);
`endif

    // Slave 0 answers in the access cycle where the watchdog would reach its limit
    cyc_setup(BASE + 32'h0020, 1'b0, 32'h0);
    for (int k = 1; k < TO; k++) begin
      cyc_access(4'b1110);
    end
    cyc_access(4'b1111);
    check_eq("edge_pready", PREADY_M,  32'h1);
    check_eq("edge_prdata", PRDATA_M,  32'hA5A5_A5A5);
    check_eq("edge_perr",   PSLVERR_M, 32'h0);
    cyc_idle();
    check_eq("edge_pulse", err_pulse, 32'h0);
    check_eq("edge_cnt",   err_count, exp_cnt);

    // Master abandons an access to a waiting slave 2
    cyc_setup(BASE + 32'h2000, 1'b0, 32'h0);
    cyc_access(4'b1011);
    check_eq("abort_wait_psel", PSEL_S, 32'h4);
    cyc_idle();
    check_eq("abort_psel",   PSEL_S,    32'h0);
    check_eq("abort_pen",    PENABLE_S, 32'h0);
    check_eq("abort_pready", PREADY_M,  32'h0);
    cyc_idle();
    check_eq("abort_pulse", err_pulse, 32'h0);
    check_eq("abort_cnt",   err_count, exp_cnt);

    // 300 back-to-back misses, then a hit on slave 3 with no setup gap
    for (int i = 0; i < 300; i++) begin
      cyc_setup(BASE + 32'h8000 + 32'(i * 4), 1'b0, 32'h0);
      cyc_access(4'hF);
      if (i == 0) check_eq("b2b_first_perr", PSLVERR_M, 32'h1);
    end
    cyc_setup(BASE + 32'h3004, 1'b1, 32'h1234_5678);
    check_eq("b2b_hit_psel",  PSEL_S,  32'h8);
    check_eq("b2b_hit_paddr", PADDR_S, 32'h004);
    cyc_access(4'hF);
    check_eq("b2b_hit_pready", PREADY_M,  32'h1);
    check_eq("b2b_hit_perr",   PSLVERR_M, 32'h0);
    cyc_idle();
    check_eq("sat_cnt",   err_count,      32'd255);
    check_eq("sat_eaddr", err_addr,       BASE + 32'h84AC);
    check_eq("sat_eto",   err_is_timeout, 32'h0);
    check_eq("sat_pulse", err_pulse,      32'h0);

    // Synchronous reset while slave 1 is holding off an access
    cyc_setup(BASE + 32'h1000, 1'b0, 32'h0);
    cyc_access(4'b1101);
    check_eq("rstx_pre_psel", PSEL_S, 32'h2);
    @(posedge PCLK); #1;
    PRESETn = 1'b0;
    @(posedge PCLK);
    @(negedge PCLK);
    check_eq("rstx_psel",    PSEL_S,         32'h0);
    check_eq("rstx_pen",     PENABLE_S,      32'h0);
    check_eq("rstx_pready",  PREADY_M,       32'h0);
    check_eq("rstx_perr",    PSLVERR_M,      32'h0);
    check_eq("rstx_prdata",  PRDATA_M,       32'h0);
    check_eq("rstx_cnt",     err_count,      32'h0);
    check_eq("rstx_eaddr",   err_addr,       32'h0);
    check_eq("rstx_pulse",   err_pulse,      32'h0);
    check_eq("rstx_eto",     err_is_timeout, 32'h0);
    @(posedge PCLK); #1;
    PRESETn = 1'b1; PSEL_M = 1'b0; PENABLE_M = 1'b0; PREADY_S = '1;
    @(negedge PCLK);

    // Bus recovers after reset
    cyc_setup(BASE + 32'h2008, 1'b0, 32'h0);
    cyc_access(4'hF);
    check_eq("post_rst_prdata", PRDATA_M, 32'h2222_3333);
    check_eq("post_rst_pready", PREADY_M, 32'h1);
    cyc_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
